id_ex_reg: RTL

ID_EX_REG -- requirements
Module: id_ex_reg

---
 rtl/pipe_pkg.sv | 30 +++
 rtl/pipe_reg.sv | 23 ++
 rtl/id_ex_reg.sv | 110 +++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: the decode control bundle and the bubble encodings
// used by both the hazard stage and the ID/EX register.
package pipe_pkg;

  typedef struct packed {
    logic       alu_src;
    logic       mem_to_reg;
    logic       reg_write;
    logic [1:0] mem_write;
    logic [1:0] alu_op;
    logic [2:0] mem_read;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);

  localparam logic [1:0] MEMWRITE_NOP = 2'b11;
  localparam logic [2:0] MEMREAD_NOP  = 3'b101;
  localparam logic [1:0] ALUOP_NOP    = 2'b00;

  // Control bundle of an inserted bubble: no write-back, no store, no load.
  localparam ctrl_t CTRL_NOP = '{
    alu_src:    1'b0,
    mem_to_reg: 1'b0,
    reg_write:  1'b0,
    mem_write:  MEMWRITE_NOP,
    alu_op:     ALUOP_NOP,
    mem_read:   MEMREAD_NOP
  };

endpackage

// File: rtl/pipe_reg.sv
// Generic pipeline register: enable to load, clear forces a fixed value.
module pipe_reg #(
  parameter int                 WIDTH   = 8,
  parameter logic [WIDTH-1:0]   CLR_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Reset and clear both force CLR_VAL; otherwise load only when enabled.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      q <= CLR_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with stall, flush-to-bubble and a saturating bubble counter.
module id_ex_reg
  import pipe_pkg::*;
#(
  parameter int PC_W   = 9,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              Stall,
  input  logic              Flush,
  input  logic              Valid_in,
  input  logic              ALUSrc_in,
  input  logic              MemtoReg_in,
  input  logic              RegWrite_in,
  input  logic [1:0]        MemWrite_in,
  input  logic [1:0]        ALUOp_in,
  input  logic [2:0]        MemRead_in,
  input  logic [PC_W-1:0]   PC_in,
  input  logic [DATA_W-1:0] RD1_in,
  input  logic [DATA_W-1:0] RD2_in,
  input  logic [DATA_W-1:0] Imm_in,
  input  logic [4:0]        RS1_in,
  input  logic [4:0]        RS2_in,
  input  logic [4:0]        RD_in,
  input  logic [2:0]        Funct3_in,
  input  logic [6:0]        Funct7_in,
  output logic              Valid_ex,
  output logic              ALUSrc_ex,
  output logic              MemtoReg_ex,
  output logic              RegWrite_ex,
  output logic [1:0]        MemWrite_ex,
  output logic [1:0]        ALUOp_ex,
  output logic [2:0]        MemRead_ex,
  output logic [PC_W-1:0]   PC_ex,
  output logic [DATA_W-1:0] RD1_ex,
  output logic [DATA_W-1:0] RD2_ex,
  output logic [DATA_W-1:0] Imm_ex,
  output logic [4:0]        RS1_ex,
  output logic [4:0]        RS2_ex,
  output logic [4:0]        RD_ex,
  output logic [2:0]        Funct3_ex,
  output logic [6:0]        Funct7_ex,
  output logic [15:0]       BubbleCount
);

  // Payload layout, MSB first: valid, control bundle, then datapath and fields.
  localparam int FIELD_W = PC_W + 3 * DATA_W + 3 * 5 + 3 + 7;
  localparam int PAY_W   = 1 + CTRL_W + FIELD_W;

  // A bubble is invalid, carries the no-op controls and zeroes everything else.
  localparam logic [PAY_W-1:0] BUBBLE = {1'b0, CTRL_NOP, {FIELD_W{1'b0}}};

  ctrl_t             ctrl_in;
  ctrl_t             ctrl_q;
  logic [PAY_W-1:0]  payload_d;
  logic [PAY_W-1:0]  payload_q;
  logic [15:0]       bubble_count;
  logic              bubble_load;

  assign ctrl_in = '{
    alu_src:    ALUSrc_in,
    mem_to_reg: MemtoReg_in,
    reg_write:  RegWrite_in,
    mem_write:  MemWrite_in,
    alu_op:     ALUOp_in,
    mem_read:   MemRead_in
  };

  assign payload_d = {Valid_in, ctrl_in, PC_in, RD1_in, RD2_in, Imm_in,
                      RS1_in, RS2_in, RD_in, Funct3_in, Funct7_in};

  // Flush wins over Stall inside pipe_reg because clear beats enable.
  pipe_reg #(
    .WIDTH   (PAY_W),
    .CLR_VAL (BUBBLE)
  ) u_payload (
    .clk   (clk),
    .reset (reset),
    .en    (~Stall),
    .clr   (Flush),
    .d     (payload_d),
    .q     (payload_q)
  );

  assign {Valid_ex, ctrl_q, PC_ex, RD1_ex, RD2_ex, Imm_ex,
          RS1_ex, RS2_ex, RD_ex, Funct3_ex, Funct7_ex} = payload_q;

  assign ALUSrc_ex   = ctrl_q.alu_src;
  assign MemtoReg_ex = ctrl_q.mem_to_reg;
  assign RegWrite_ex = ctrl_q.reg_write;
  assign MemWrite_ex = ctrl_q.mem_write;
  assign ALUOp_ex    = ctrl_q.alu_op;
  assign MemRead_ex  = ctrl_q.mem_read;

  // An edge presents a bubble when it flushes, or loads an invalid instruction unstalled.
  assign bubble_load = Flush | (~Stall & ~Valid_in);

  // Count presented bubbles, saturating at all-ones; reset clears without counting.
  always_ff @(posedge clk) begin
    if (reset) begin
      bubble_count <= 16'h0000;
    end else if (bubble_load && (bubble_count != 16'hFFFF)) begin
      bubble_count <= bubble_count + 16'd1;
    end
  end

  assign BubbleCount = bubble_count;

endmodule
